mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single off-chip data-memory port between the instruction-fetch side (read-only line refills) and the data-cache side (line refills and write-backs).
- Sequences one transaction at a time, returns read data to the granted requester, and drives the pipeline-wide stall that freezes the IF/ID, ID/EX, EX/MEM and MEM/WB registers while any memory request is outstanding.
- Includes a watchdog that turns a hung memory transaction into a sticky error.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache-line data width.
- TIMEOUT, 64, maximum BUSY cycles to wait for mem_ack_i before aborting; must be >= 2.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- i_req_i  in  1  I-side request; level, held until i_ack_o is sampled high.
- i_addr_i  in  ADDR_W  I-side line address.
- i_ack_o  out  1  one-cycle completion pulse to I-side.
- d_req_i  in  1  D-side request; level, held until d_ack_o is sampled high.
- d_write_i  in  1  D-side: 1 = write-back, 0 = refill.
- d_addr_i  in  ADDR_W  D-side line address.
- d_wdata_i  in  LINE_W  D-side write-back line.
- d_ack_o  out  1  one-cycle completion pulse to D-side.
- rdata_o  out  LINE_W  registered read line; valid while either ack_o is high.
- mem_enable_o  out  1  memory request; held high for the whole transaction.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  LINE_W  memory write data.
- mem_ack_i  in  1  memory completion pulse.
- mem_rdata_i  in  LINE_W  memory read data; valid with mem_ack_i.
- stall_o  out  1  pipeline stall (to stall_i of all pipeline registers).
- err_o  out  1  sticky watchdog error.

Behaviour:
- Reset (async, rst_i=1):
  - State returns to IDLE and the watchdog counter clears.
  - Outputs: i_ack_o=0, d_ack_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_o=0.
  - Reset mid-transaction abandons the transaction; no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If d_req_i=1, grant D. D has fixed priority because it is the older instruction.
  - Otherwise, if i_req_i=1, grant I.
  - On a grant, the next edge registers mem_addr_o, mem_write_o (D-side d_write_i; I-side 0), mem_wdata_o (D-side d_wdata_i; else 0) and the grant owner; sets mem_enable_o=1; moves to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_wdata_o are held stable.
  - The watchdog counts BUSY cycles.
  - On mem_ack_i=1: the next edge captures rdata_o <= mem_rdata_i (0 for writes), drops mem_enable_o and mem_write_o, and moves to RESP.
  - If the count reaches TIMEOUT without mem_ack_i: the next edge sets err_o=1 (sticky until reset), sets rdata_o=0, drops mem_enable_o and moves to RESP.
  - A mem_ack_i in the same cycle as the timeout wins; it is a normal completion.
- RESP:
  - Exactly one of i_ack_o or d_ack_o is high for one cycle, per the grant owner.
  - Next state is always IDLE.
  - The requester deasserts req on the edge at which it samples its ack, so the request is never re-granted. A req that is still high in IDLE is treated as a new request.
- Back-to-back: with d_req and i_req both pending, D completes first. I is granted in the IDLE cycle that follows D's RESP, provided D has dropped its request.
- Latency:
  - IDLE grant to mem_enable_o high: 1 cycle.
  - mem_ack_i to ack_o: 1 cycle.
  - Minimum req-to-ack: 2 cycles.
- stall_o (combinational) = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o). The stall releases in the same cycle the ack pulses.
- mem_ack_i outside BUSY is ignored.
- err_o does not block further transactions.

Test Plan:
- D refill: d_req=1, d_write=0, d_addr=0x0000_0400; memory acks 3 cycles after mem_enable_o rises with rdata=0xA5…A5 -> mem_addr_o=0x400, mem_write_o=0, and d_ack_o pulses 1 cycle after mem_ack with rdata_o=0xA5…A5; stall_o is high from d_req until the ack cycle.
- Write-back: d_write=1, d_addr=0x800, d_wdata=0x1234… -> mem_write_o=1 and mem_wdata_o=0x1234… stable through BUSY; d_ack_o pulses with rdata_o=0.
- Simultaneous requests: i_req and d_req rise in the same cycle (i_addr=0x100, d_addr=0x200) -> first mem_addr_o=0x200; d_ack precedes i_ack; the second transaction starts with mem_addr_o=0x100; no overlap of mem_enable_o periods.
- Timeout: I request with memory never acking, TIMEOUT=64 -> after 64 BUSY cycles err_o=1 and i_ack_o pulses with rdata_o=0; a following D request completes normally and err_o stays 1.
- Reset mid-BUSY: rst_i asserted during a D refill -> mem_enable_o=0 immediately (async), no d_ack_o, err_o=0, state IDLE after release.
- Spurious ack: mem_ack_i pulsed in IDLE -> no ack_o, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single off-chip memory port between I-side refills and D-side refills/write-backs.
// One transaction at a time, D-side has fixed priority, and a watchdog turns a hung access into a sticky error.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    input  logic              d_req_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [LINE_W-1:0] rdata_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e            state_q, state_d;
    logic              own_d_q, own_d_d;   // 1: transaction belongs to the D-side
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic              timeout;

    // wdog_q counts completed BUSY cycles, so this fires in the TIMEOUT-th BUSY cycle
    assign timeout = (wdog_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            own_d_q      <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            own_d_q      <= own_d_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            wdog_q       <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (d_req_i || i_req_i) state_d = BUSY;
            BUSY:    if (mem_ack_i || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        own_d_d      = own_d_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        wdog_d       = '0;
        case (state_q)
            IDLE: begin
                if (d_req_i) begin
                    own_d_d      = 1'b1;
                    mem_enable_d = 1'b1;
                    mem_write_d  = d_write_i;
                    mem_addr_d   = d_addr_i;
                    mem_wdata_d  = d_wdata_i;
                end else if (i_req_i) begin
                    own_d_d      = 1'b0;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = i_addr_i;
                    mem_wdata_d  = '0;
                end
            end
            BUSY: begin
                wdog_d = wdog_q + CNT_W'(1);
                // a completion in the timeout cycle still counts as a normal completion
                if (mem_ack_i) begin
                    rdata_d      = mem_write_q ? '0 : mem_rdata_i;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                end else if (timeout) begin
                    rdata_d      = '0;
                    err_d        = 1'b1;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign i_ack_o      = (state_q == RESP) && !own_d_q;
    assign d_ack_o      = (state_q == RESP) &&  own_d_q;
    assign rdata_o      = rdata_q;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign err_o        = err_q;
    assign stall_o      = (i_req_i && !i_ack_o) || (d_req_i && !d_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory requests and acks,
// a monitor pops and compares whenever the DUT starts a memory access or pulses an ack.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    typedef struct {
        logic              is_d;
        logic [LINE_W-1:0] rdata;
        logic              err;
    } ack_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              i_req_i, d_req_i, d_write_i;
    logic [ADDR_W-1:0] i_addr_i, d_addr_i;
    logic [LINE_W-1:0] d_wdata_i;
    logic              i_ack_o, d_ack_o;
    logic [LINE_W-1:0] rdata_o;
    logic              mem_enable_o, mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              stall_o, err_o;

    int n_pass  = 0;
    int n_total = 0;

    req_t req_q[$];
    ack_t ack_q[$];

    // memory model controls
    int                mem_lat  = 3;
    bit                ack_en   = 1'b1;
    bit                spur     = 1'b0;
    logic [LINE_W-1:0] mem_data = '0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o),
        .d_req_i(d_req_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .rdata_o(rdata_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // memory: acks mem_lat cycles after mem_enable_o rises, unless acks are disabled
    initial begin
        int busy_cnt;
        busy_cnt    = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_ack_i = spur;
            if (rst_i) busy_cnt = 0;
            else if (mem_enable_o) begin
                busy_cnt++;
                if (ack_en && busy_cnt == mem_lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_data;
                end
            end else busy_cnt = 0;
        end
    end

    // monitor / scoreboard
    initial begin
        bit   prev_en;
        req_t hold;
        req_t er;
        ack_t ea;
        prev_en = 1'b0;
        hold    = '{addr: '0, wr: 1'b0, wdata: '0};
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_en = 1'b0;
            end else begin
                if (mem_enable_o && !prev_en) begin
                    chk("req_q_nonempty", LINE_W'(req_q.size() != 0), LINE_W'(1));
                    if (req_q.size() != 0) begin
                        er   = req_q.pop_front();
                        hold = er;
                        chk("mem_addr",  LINE_W'(mem_addr_o),  LINE_W'(er.addr));
                        chk("mem_write", LINE_W'(mem_write_o), LINE_W'(er.wr));
                        chk("mem_wdata", mem_wdata_o, er.wdata);
                    end
                end else if (mem_enable_o) begin
                    chk("hold_addr",  LINE_W'(mem_addr_o),  LINE_W'(hold.addr));
                    chk("hold_write", LINE_W'(mem_write_o), LINE_W'(hold.wr));
                    chk("hold_wdata", mem_wdata_o, hold.wdata);
                end
                if (i_ack_o || d_ack_o) begin
                    chk("ack_q_nonempty", LINE_W'(ack_q.size() != 0), LINE_W'(1));
                    if (ack_q.size() != 0) begin
                        ea = ack_q.pop_front();
                        chk("ack_owner", LINE_W'({d_ack_o, i_ack_o}), LINE_W'({ea.is_d, !ea.is_d}));
                        chk("rdata", rdata_o, ea.rdata);
                        chk("err", LINE_W'(err_o), LINE_W'(ea.err));
                    end
                end
                prev_en = mem_enable_o;
            end
        end
    end

    // requester handshake; n counts negedges from the request cycle up to the ack cycle
    task automatic request(input bit is_d, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [LINE_W-1:0] wd, input int exp_n, input bit chk_st);
        int n;
        bit got;
        @(posedge clk_i); #1;
        if (is_d) begin
            d_write_i = wr; d_addr_i = a; d_wdata_i = wd; d_req_i = 1'b1;
        end else begin
            i_addr_i = a; i_req_i = 1'b1;
        end
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk_i); n++;
            if (is_d ? d_ack_o : i_ack_o) got = 1'b1;
            else if (chk_st) chk("stall_held", LINE_W'(stall_o), LINE_W'(1));
        end
        chk("ack_seen", LINE_W'(got), LINE_W'(1));
        if (got && exp_n > 0) chk("req_to_ack", LINE_W'(n), LINE_W'(exp_n));
        if (got && chk_st) chk("stall_release", LINE_W'(stall_o), LINE_W'(0));
        @(posedge clk_i); #1;
        if (is_d) d_req_i = 1'b0;
        else i_req_i = 1'b0;
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        i_req_i = 1'b0; d_req_i = 1'b0; d_write_i = 1'b0;
        i_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
        #1;
        chk("rst_acks",  LINE_W'({i_ack_o, d_ack_o}), LINE_W'(0));
        chk("rst_en_wr", LINE_W'({mem_enable_o, mem_write_o}), LINE_W'(0));
        chk("rst_addr",  LINE_W'(mem_addr_o), LINE_W'(0));
        chk("rst_wdata", mem_wdata_o, LINE_W'(0));
        chk("rst_rdata", rdata_o, LINE_W'(0));
        chk("rst_err",   LINE_W'(err_o), LINE_W'(0));
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // D refill, memory acks 3 cycles after enable
        mem_lat = 3; mem_data = {32{8'hA5}};
        req_q.push_back('{addr: 32'h400, wr: 1'b0, wdata: '0});
        ack_q.push_back('{is_d: 1'b1, rdata: {32{8'hA5}}, err: 1'b0});
        request(1'b1, 1'b0, 32'h400, '0, 5, 1'b1);

        // write-back: read data from memory must not reach rdata_o
        mem_lat = 2; mem_data = {32{8'hFF}};
        req_q.push_back('{addr: 32'h800, wr: 1'b1, wdata: {16{16'h1234}}});
        ack_q.push_back('{is_d: 1'b1, rdata: '0, err: 1'b0});
        request(1'b1, 1'b1, 32'h800, {16{16'h1234}}, 4, 1'b1);

        // simultaneous requests: D first, then I
        mem_lat = 1; mem_data = {64{4'h6}};
        req_q.push_back('{addr: 32'h200, wr: 1'b0, wdata: '0});
        req_q.push_back('{addr: 32'h100, wr: 1'b0, wdata: '0});
        ack_q.push_back('{is_d: 1'b1, rdata: {64{4'h6}}, err: 1'b0});
        ack_q.push_back('{is_d: 1'b0, rdata: {64{4'h6}}, err: 1'b0});
        fork
            request(1'b1, 1'b0, 32'h200, '0, 3, 1'b0);
            request(1'b0, 1'b0, 32'h100, '0, 0, 1'b0);
        join

        // timeout on an I refill, then a normal D refill with err staying set
        ack_en = 1'b0;
        req_q.push_back('{addr: 32'h300, wr: 1'b0, wdata: '0});
        ack_q.push_back('{is_d: 1'b0, rdata: '0, err: 1'b1});
        request(1'b0, 1'b0, 32'h300, '0, TIMEOUT + 2, 1'b1);
        ack_en = 1'b1; mem_lat = 2; mem_data = {8{32'hC0FFEE01}};
        req_q.push_back('{addr: 32'h440, wr: 1'b0, wdata: '0});
        ack_q.push_back('{is_d: 1'b1, rdata: {8{32'hC0FFEE01}}, err: 1'b1});
        request(1'b1, 1'b0, 32'h440, '0, 4, 1'b1);
        chk("err_sticky", LINE_W'(err_o), LINE_W'(1));

        // spurious memory ack in IDLE
        @(posedge clk_i); #2; spur = 1'b1;
        @(posedge clk_i); #2; spur = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk("spur_idle", LINE_W'({mem_enable_o, i_ack_o, d_ack_o, stall_o}), LINE_W'(0));
        end

        // reset in the middle of a D refill
        ack_en = 1'b0;
        req_q.push_back('{addr: 32'h600, wr: 1'b0, wdata: '0});
        @(posedge clk_i); #1;
        d_write_i = 1'b0; d_addr_i = 32'h600; d_req_i = 1'b1;
        n = 0;
        while (!mem_enable_o && n < 20) begin @(posedge clk_i); #1; n++; end
        chk("mid_busy_en", LINE_W'(mem_enable_o), LINE_W'(1));
        repeat (3) @(posedge clk_i);
        #2; rst_i = 1'b1;
        #1;
        chk("async_en", LINE_W'(mem_enable_o), LINE_W'(0));
        chk("async_err", LINE_W'(err_o), LINE_W'(0));
        chk("async_ack", LINE_W'({i_ack_o, d_ack_o}), LINE_W'(0));
        d_req_i = 1'b0; ack_en = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            chk("post_rst_idle", LINE_W'({mem_enable_o, i_ack_o, d_ack_o}), LINE_W'(0));
        end

        // normal I refill after reset
        mem_lat = 2; mem_data = {16{16'hBEEF}};
        req_q.push_back('{addr: 32'h700, wr: 1'b0, wdata: '0});
        ack_q.push_back('{is_d: 1'b0, rdata: {16{16'hBEEF}}, err: 1'b0});
        request(1'b0, 1'b0, 32'h700, '0, 4, 1'b1);

        repeat (3) @(negedge clk_i);
        chk("req_q_drained", LINE_W'(req_q.size()), LINE_W'(0));
        chk("ack_q_drained", LINE_W'(ack_q.size()), LINE_W'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
